// File: rtl/led_frame_feeder_pkg.sv
// -----------------------------------------------------------------------------
// led_frame_feeder_pkg
// Shared constants and types for the 4x4 LED frame feeder and its mirror of
// the display scanner's slot counter.
//   LED_NLEDS       : LEDs per frame (4 rows x 4 columns)
//   LED_IDX_W       : width of the scanner slot counter
//   LED_SLOT_FIRST  : first LED slot of a frame (frame boundary)
//   LED_SLOT_LAST   : last LED slot of a frame
//   led_frame_t     : one frame bitmap, bit 4*r+c = LED at row r, column c
// -----------------------------------------------------------------------------
package led_frame_feeder_pkg;

   localparam int LED_NLEDS = 16;
   localparam int LED_IDX_W = 5;

   localparam logic [4:0] LED_SLOT_FIRST = 5'd1;
   localparam logic [4:0] LED_SLOT_LAST  = 5'd16;

   typedef logic [15:0] led_frame_t;

   // True when a slot number addresses a real LED (1..16) rather than a dead slot.
   function automatic logic slot_is_led(input logic [4:0] slot);
      return (slot >= LED_SLOT_FIRST) && (slot <= LED_SLOT_LAST);
   endfunction

endpackage

// File: rtl/led_frame_feeder_if.sv
// -----------------------------------------------------------------------------
// led_frame_feeder_if
// Valid/ready frame transfer channel into the LED frame feeder.
//   frame_data  : 16-bit frame bitmap (master -> slave)
//   frame_valid : frame_data is valid   (master -> slave)
//   frame_ready : slave can take a frame (slave -> master)
// A transfer happens on any clock edge with frame_valid && frame_ready.
// -----------------------------------------------------------------------------
interface led_frame_feeder_if;
   import led_frame_feeder_pkg::*;

   led_frame_t frame_data;
   logic       frame_valid;
   logic       frame_ready;

   modport master (
      output frame_data,
      output frame_valid,
      input  frame_ready
   );

   modport slave (
      input  frame_data,
      input  frame_valid,
      output frame_ready
   );

endinterface

// File: rtl/led_scan_mirror.sv
// -----------------------------------------------------------------------------
// led_scan_mirror
// Exact copy of the display scanner's 5-bit slot counter. The scanner only
// jumps from slot 16 back to slot 1 when LED 16 is dark; when LED 16 is lit it
// keeps counting through dead slots 17..31 and 0 before reaching 1 again.
//   clk             : system clock
//   rst_n           : asynchronous active-low reset (counter -> 0)
//   data_led_i      : the data_led value currently presented to the scanner
//   idx_o           : current slot number
//   idx_next_o      : slot number after the coming edge
//   boundary_next_o : the coming edge starts a new frame (next slot is 1)
// -----------------------------------------------------------------------------
module led_scan_mirror
   import led_frame_feeder_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_led_i,
   output logic [4:0] idx_o,
   output logic [4:0] idx_next_o,
   output logic       boundary_next_o
);

   logic [4:0] idx_q;
   logic [4:0] idx_d;

   // Next slot: short wrap only after a dark LED 16, otherwise plain mod-32 step.
   always_comb begin
      idx_d = idx_q + 5'd1;
      if ((idx_q == LED_SLOT_LAST) && (data_led_i == 1'b0)) begin
         idx_d = LED_SLOT_FIRST;
      end else begin
         idx_d = idx_q + 5'd1;
      end
   end

   // Slot counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= 5'd0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx_o           = idx_q;
   assign idx_next_o      = idx_d;
   assign boundary_next_o = (idx_d == LED_SLOT_FIRST);

endmodule

// File: rtl/led_frame_feeder.sv
// -----------------------------------------------------------------------------
// led_frame_feeder
// Holds the frame shown on the 4x4 LED scanner and feeds it bit-serially on
// data_led in step with the scanner's slot counter. New frames arrive over a
// valid/ready channel into a shadow buffer and replace the active frame only
// at a frame boundary, so a frame is never torn.
//   clk         : system clock shared with the scanner
//   rst_n       : asynchronous active-low reset; release must coincide with
//                 the scanner's own power-up
//   frame_if    : slave side of the frame channel (data, valid, ready)
//   data_led    : serial LED data into the scanner (registered)
//   scan_idx    : mirrored scanner slot counter
//   frame_start : registered pulse during the cycle where scan_idx == 1
// -----------------------------------------------------------------------------
module led_frame_feeder
   import led_frame_feeder_pkg::*;
#(
   parameter int NLEDS = LED_NLEDS,
   parameter int IDX_W = LED_IDX_W
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   led_frame_feeder_if.slave    frame_if,
   output logic                 data_led,
   output logic [IDX_W-1:0]     scan_idx,
   output logic                 frame_start
);

   logic [NLEDS-1:0] active_q;
   logic [NLEDS-1:0] active_d;
   logic [NLEDS-1:0] shadow_q;
   logic [NLEDS-1:0] shadow_d;
   logic             pending_q;
   logic             pending_d;
   logic             data_led_q;
   logic             data_led_d;
   logic             frame_start_q;
   logic             frame_start_d;

   logic [4:0]       idx_s;
   logic [4:0]       idx_next_s;
   logic             boundary_next_s;
   logic             accept_s;
   logic [4:0]       idx_next_m1_s;
   logic [3:0]       bit_sel_s;

   led_scan_mirror u_mirror (
      .clk             (clk),
      .rst_n           (rst_n),
      .data_led_i      (data_led_q),
      .idx_o           (idx_s),
      .idx_next_o      (idx_next_s),
      .boundary_next_o (boundary_next_s)
   );

   assign accept_s = frame_if.frame_valid && !pending_q;

   // Slot n shows bit n-1; for slots 1..16 the low four bits of n-1 select it
   // (slot 16 = 5'b10000 -> bit 15).
   assign idx_next_m1_s = idx_next_s - 5'd1;
   assign bit_sel_s     = idx_next_m1_s[3:0];

   // Buffer, handshake and output next-state logic.
   always_comb begin
      active_d      = active_q;
      shadow_d      = shadow_q;
      pending_d     = pending_q;
      data_led_d    = 1'b0;
      frame_start_d = 1'b0;

      // Swap uses the pre-edge pending flag; an accept on this same edge can
      // only happen with pending clear, so it never swaps immediately.
      if (boundary_next_s && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end else begin
         active_d  = active_q;
      end

      if (accept_s) begin
         shadow_d  = frame_if.frame_data;
         pending_d = 1'b1;
      end else begin
         shadow_d  = shadow_q;
      end

      // Output bit is taken from the post-swap frame so a new frame starts
      // cleanly at its own bit 0.
      if (slot_is_led(idx_next_s)) begin
         data_led_d = active_d[bit_sel_s];
      end else begin
         data_led_d = 1'b0;
      end

      frame_start_d = boundary_next_s;
   end

   // Buffer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q      <= '0;
         shadow_q      <= '0;
         pending_q     <= 1'b0;
         data_led_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         active_q      <= active_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         data_led_q    <= data_led_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign frame_if.frame_ready = !pending_q;
   assign data_led             = data_led_q;
   assign frame_start          = frame_start_q;
   assign scan_idx             = idx_s;

endmodule

// File: tb/tb_led_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_led_frame_feeder
// Self-checking bench for led_frame_feeder. A reference model of the scanner
// and the double-buffered frame store is stepped once per clock; DUT outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_led_frame_feeder;

   logic       clk;
   logic       rst_n;
   logic       data_led;
   logic [4:0] scan_idx;
   logic       frame_start;

   led_frame_feeder_if fif ();

   led_frame_feeder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_if    (fif),
      .data_led    (data_led),
      .scan_idx    (scan_idx),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state
   int          m_idx;
   bit          m_led;
   bit          m_start;
   bit          m_pending;
   bit [15:0]   m_active;
   bit [15:0]   m_shadow;

   task automatic model_reset();
      m_idx = 0; m_led = 0; m_start = 0; m_pending = 0;
      m_active = 16'h0000; m_shadow = 16'h0000;
   endtask

   // Advance the model by one clock using the current inputs, then wait for
   // the edge and settle.
   task automatic tick();
      int  nidx;
      bit  acc;
      acc  = (fif.frame_valid === 1'b1) && !m_pending;
      nidx = (m_idx == 16 && !m_led) ? 1 : (m_idx + 1) % 32;
      if (nidx == 1 && m_pending) begin
         m_active  = m_shadow;
         m_pending = 0;
      end
      if (acc) begin
         m_shadow  = fif.frame_data;
         m_pending = 1;
      end
      m_idx   = nidx;
      m_led   = (nidx >= 1 && nidx <= 16) ? m_active[nidx-1] : 1'b0;
      m_start = (nidx == 1);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fif.frame_valid = 1'b0;
      fif.frame_data  = 16'h0000;
      model_reset();
      #1;
      n_checks++;
      if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got idx=%0d led=%0b start=%0b ready=%0b, want idx=0 led=0 start=0 ready=1",
                  scan_idx, data_led, frame_start, fif.frame_ready);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), m_led, m_start, !m_pending}) begin
            n_fail++;
            $display("FAIL reset_scan cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=%0b start=%0b ready=%0b",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_led, m_start, !m_pending);
         end
      end
      // with an empty frame the counter must follow 1..16 with period 16
      n_checks++;
      if (scan_idx !== 5'((40 - 1) % 16 + 1)) begin
         n_fail++;
         $display("FAIL reset_period: got idx=%0d want %0d", scan_idx, (40 - 1) % 16 + 1);
      end
   endtask

   task automatic test_single_first();
      fif.frame_data  = 16'h0001;
      fif.frame_valid = 1'b1;
      tick();
      fif.frame_valid = 1'b0;
      n_checks++;
      if (fif.frame_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL first_ready_drop: got ready=%0b want 0", fif.frame_ready);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), m_led, m_start, !m_pending}) begin
            n_fail++;
            $display("FAIL first_bit cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=%0b start=%0b ready=%0b",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_led, m_start, !m_pending);
         end
      end
      // frame 0x0001 is shown by now: LED lit exactly at slot 1
      for (int i = 0; i < 16; i++) begin
         tick();
         n_checks++;
         if (data_led !== (scan_idx == 5'd1)) begin
            n_fail++;
            $display("FAIL first_only_slot1: idx=%0d got led=%0b want %0b", scan_idx, data_led, scan_idx == 5'd1);
         end
      end
   endtask

   task automatic test_last_lit();
      int starts;
      int period;
      fif.frame_data  = 16'h8000;
      fif.frame_valid = 1'b1;
      tick();
      fif.frame_valid = 1'b0;
      starts = 0;
      period = 0;
      // first start pulse swaps the frame in; measure to the one after that
      for (int i = 0; i < 100 && starts < 3; i++) begin
         tick();
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), m_led, m_start, !m_pending}) begin
            n_fail++;
            $display("FAIL last_bit cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=%0b start=%0b ready=%0b",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_led, m_start, !m_pending);
         end
         if (starts >= 1) period++;
         if (frame_start === 1'b1) begin
            starts++;
            if (starts == 3) begin
               n_checks++;
               if (period !== 32) begin
                  n_fail++;
                  $display("FAIL last_period: got %0d cycles want 32", period);
               end
            end
            period = 0;
         end
      end
      n_checks++;
      if (starts < 3) begin
         n_fail++;
         $display("FAIL last_timeout: got %0d frame starts want 3", starts);
      end
   endtask

   task automatic test_back_to_back();
      int waited;
      fif.frame_data  = 16'hA5A5;
      fif.frame_valid = 1'b1;
      tick();
      fif.frame_data  = 16'h5A5A;
      waited = 0;
      // hold the second frame until it is taken
      while (fif.frame_ready !== 1'b1 && waited < 80) begin
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), m_led, m_start, !m_pending}) begin
            n_fail++;
            $display("FAIL b2b_hold cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=%0b start=%0b ready=%0b",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_led, m_start, !m_pending);
         end
         tick();
         waited++;
      end
      n_checks++;
      if (waited >= 80 || m_active !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL b2b_first_swap: waited %0d, model active %h want A5A5", waited, m_active);
      end
      tick();
      fif.frame_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), m_led, m_start, !m_pending}) begin
            n_fail++;
            $display("FAIL b2b_run cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=%0b start=%0b ready=%0b",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_led, m_start, !m_pending);
         end
      end
      // 0x5A5A: bit k-1 lit for slot k; check one full frame directly
      for (int i = 0; i < 16; i++) begin
         tick();
         if (scan_idx >= 5'd1 && scan_idx <= 5'd16) begin
            n_checks++;
            if (data_led !== ((16'h5A5A >> (scan_idx - 5'd1)) & 16'h1)) begin
               n_fail++;
               $display("FAIL b2b_second_shown: idx=%0d got led=%0b", scan_idx, data_led);
            end
         end
      end
   endtask

   task automatic test_valid_at_boundary();
      bit found;
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         if (!m_pending && ((m_idx == 16 && !m_led) || m_idx == 0)) found = 1;
         else tick();
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL bnd_search: no boundary with pending clear found");
      end
      fif.frame_data  = 16'h0F0F;
      fif.frame_valid = 1'b1;
      tick();
      fif.frame_valid = 1'b0;
      n_checks++;
      if ({scan_idx, fif.frame_ready} !== {5'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL bnd_accept: got idx=%0d ready=%0b want idx=1 ready=0", scan_idx, fif.frame_ready);
      end
      for (int i = 0; i < 50; i++) begin
         tick();
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), m_led, m_start, !m_pending}) begin
            n_fail++;
            $display("FAIL bnd_run cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=%0b start=%0b ready=%0b",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_led, m_start, !m_pending);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         fif.frame_valid = ($urandom_range(0, 3) == 0);
         fif.frame_data  = 16'($urandom);
         tick();
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), m_led, m_start, !m_pending}) begin
            n_fail++;
            $display("FAIL random cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=%0b start=%0b ready=%0b",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_led, m_start, !m_pending);
         end
      end
      fif.frame_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int waited;
      waited = 0;
      while (!(m_start && !m_pending) && waited < 80) begin
         tick();
         waited++;
      end
      fif.frame_data  = 16'hFFFF;
      fif.frame_valid = 1'b1;
      tick();
      fif.frame_valid = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if (waited >= 80 || fif.frame_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_setup: waited %0d ready=%0b want pending frame", waited, fif.frame_ready);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL rstmid_async: got idx=%0d led=%0b start=%0b ready=%0b, want idx=0 led=0 start=0 ready=1",
                  scan_idx, data_led, frame_start, fif.frame_ready);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         n_checks++;
         if ({scan_idx, data_led, frame_start, fif.frame_ready} !== {5'(m_idx), 1'b0, m_start, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_discard cyc%0d: got idx=%0d led=%0b start=%0b ready=%0b, want idx=%0d led=0 start=%0b ready=1",
                     cyc, scan_idx, data_led, frame_start, fif.frame_ready, m_idx, m_start);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_first();
      test_last_lit();
      test_back_to_back();
      test_valid_at_boundary();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
